vec_mem_sequencer: RTL and testbench

- Sequences vector memory instructions (VLDH, VSTB) onto the single-port, lane-wide data memory.
- Splits one vector access into LANES sequential single-lane accesses using a req/ack handshake. Assembles load data into a full vector.
- Holds the pipeline stall while the access is in flight. Sits between the decode/execute stage (driven by control-unit vector memory signals) and the data memory port.

---
 rtl/vec_mem_sequencer.sv | 169 ++++++++++++++++
 tb/tb_vec_mem_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_mem_sequencer.sv
// vec_mem_sequencer: splits one vector load/store into LANES single-lane
// accesses on a lane-wide memory port using a req/ack handshake, assembles
// load data into a full vector and stalls the pipeline while in flight.
// Optional feature: define VMEM_TIMEOUT_EN to abort a lane that waits
// TIMEOUT cycles for mem_ack, raising a sticky err flag.
module vec_mem_sequencer #(
  parameter int LANES       = 4,
  parameter int LANE_W      = 8,
  parameter int ADDR_W      = 16,
  parameter int ADDR_STRIDE = 1,
  parameter int TIMEOUT     = 15
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic                      i_is_store,
  input  logic [ADDR_W-1:0]         i_base_addr,
  input  logic [LANES*LANE_W-1:0]   i_vec_wdata,
  input  logic                      i_flush,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [LANES*LANE_W-1:0]   o_vec_rdata,
  output logic                      o_err,
  output logic                      o_mem_req,
  output logic                      o_mem_we,
  output logic [ADDR_W-1:0]         o_mem_addr,
  output logic [LANE_W-1:0]         o_mem_wdata,
  input  logic [LANE_W-1:0]         i_mem_rdata,
  input  logic                      i_mem_ack
);

  localparam int LANE_CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int VEC_W      = LANES * LANE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [LANE_CNT_W-1:0] r_lane;
  logic [VEC_W-1:0]      r_wdata_sh;
  logic [VEC_W-1:0]      r_vec_rdata;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [LANE_W-1:0]     r_mem_wdata;

  logic w_accept;
  logic w_last;
  logic w_timeout;

  // A new access is taken from IDLE or DONE (back-to-back); flush always wins.
  assign w_accept = (r_state != ST_REQ) && i_start && !i_flush;
  assign w_last   = (r_lane == LANE_CNT_W'(LANES - 1));

`ifdef VMEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  logic [WAIT_W-1:0] r_wait;
  logic              r_err;

  // The lane gives up on the cycle its wait count would reach TIMEOUT.
  assign w_timeout = (r_state == ST_REQ) && !i_flush && !i_mem_ack &&
                     (r_wait == WAIT_W'(TIMEOUT - 1));

  // Per-lane ack wait counter and sticky timeout error, cleared by a new access.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_err <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
      if ((r_state != ST_REQ) || i_mem_ack || i_flush) begin
        r_wait <= '0;
      end else begin
        r_wait <= r_wait + WAIT_W'(1);
      end
    end
  end

  assign o_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign o_err     = 1'b0;
`endif

  // Sequencer FSM: all memory-port and pipeline outputs are registered here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_lane      <= '0;
      r_wdata_sh  <= '0;
      r_vec_rdata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_REQ: begin
          if (i_flush) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end else if (i_mem_ack) begin
            if (!r_mem_we) begin
              r_vec_rdata[r_lane*LANE_W +: LANE_W] <= i_mem_rdata;
            end
            if (w_last) begin
              r_state   <= ST_DONE;
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
              r_mem_req <= 1'b0;
              r_mem_we  <= 1'b0;
            end else begin
              r_lane      <= r_lane + LANE_CNT_W'(1);
              r_mem_addr  <= r_mem_addr + ADDR_W'(ADDR_STRIDE);
              r_mem_wdata <= r_wdata_sh[LANE_W-1:0];
              r_wdata_sh  <= r_wdata_sh >> LANE_W;
            end
          end else if (w_timeout) begin
            r_state   <= ST_DONE;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end
        end
        default: begin
          r_busy    <= 1'b0;
          r_mem_req <= 1'b0;
          if (w_accept) begin
            r_state     <= ST_REQ;
            r_lane      <= '0;
            r_busy      <= 1'b1;
            r_mem_req   <= 1'b1;
            r_mem_we    <= i_is_store;
            r_mem_addr  <= i_base_addr;
            r_mem_wdata <= i_vec_wdata[LANE_W-1:0];
            r_wdata_sh  <= i_vec_wdata >> LANE_W;
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_vec_rdata = r_vec_rdata;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// tb_vec_mem_sequencer: self-checking bench for vec_mem_sequencer with a
// behavioural memory responder and a byte-array reference model.
// Build with VMEM_TIMEOUT_EN defined to exercise the timeout feature.
module tb_vec_mem_sequencer;

  localparam int LANES   = 4;
  localparam int LANE_W  = 8;
  localparam int ADDR_W  = 16;
  localparam int STRIDE  = 1;
  localparam int TIMEOUT = 15;

  logic        clock = 1'b0;
  logic        rstN = 1'b0;
  logic        start = 1'b0;
  logic        isStore = 1'b0;
  logic [15:0] baseAddr = '0;
  logic [31:0] vecWdata = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] vecRdata;
  logic        err;
  logic        memReq;
  logic        memWe;
  logic [15:0] memAddr;
  logic [7:0]  memWdata;
  logic [7:0]  memRdata = '0;
  logic        memAck = 1'b0;

  int nCompared = 0;
  int nMismatch = 0;

  int ackDelay = 0;
  bit ackNever = 1'b0;
  int waitCnt = 0;
  int holdErr = 0;
  bit prevWait = 1'b0;
  logic [15:0] prevAddr = '0;
  logic [7:0]  prevWdata = '0;
  logic        prevWe = 1'b0;

  logic [7:0]  mem [logic [15:0]];
  logic [7:0]  refMem [logic [15:0]];
  logic [15:0] beatAddr [$];
  logic [7:0]  beatData [$];
  logic        beatWe [$];

  logic [31:0] lastRdata = '0;

  typedef struct {
    bit          isStore;
    logic [15:0] base;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] expRdata;
    int          expLat;
  } vecRec_t;

  vecRec_t vecTable [6];

  vec_mem_sequencer #(
    .LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W),
    .ADDR_STRIDE(STRIDE), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clock), .i_rst_n(rstN), .i_start(start), .i_is_store(isStore),
    .i_base_addr(baseAddr), .i_vec_wdata(vecWdata), .i_flush(flush),
    .o_busy(busy), .o_done(done), .o_vec_rdata(vecRdata), .o_err(err),
    .o_mem_req(memReq), .o_mem_we(memWe), .o_mem_addr(memAddr),
    .o_mem_wdata(memWdata), .i_mem_rdata(memRdata), .i_mem_ack(memAck)
  );

  // Free-running clock
  always #5 clock = ~clock;

  // Power-up memory contents for addresses never written
  function automatic logic [7:0] initByte(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] memRead(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return initByte(a);
  endfunction

  function automatic logic [7:0] refRead(input logic [15:0] a);
    if (refMem.exists(a)) return refMem[a];
    return initByte(a);
  endfunction

  function automatic logic [15:0] laneAddr(input logic [15:0] b, input int i);
    return b + 16'(i * STRIDE);
  endfunction

  function automatic logic [31:0] modelLoad(input logic [15:0] b);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) v[8*i +: 8] = refRead(laneAddr(b, i));
    return v;
  endfunction

  task automatic modelStore(input logic [15:0] b, input logic [31:0] wd, input int nLanes);
    for (int i = 0; i < nLanes; i++) refMem[laneAddr(b, i)] = wd[8*i +: 8];
  endtask

  // Memory responder: ack policy and read data, set up away from the active edge
  always @(negedge clock) begin
    memAck = memReq && !ackNever && (waitCnt >= ackDelay);
    memRdata = memRead(memAddr);
  end

  // Memory responder: perform accepted beats and watch request stability
  always @(posedge clock) begin
    if (memReq && prevWait &&
        (memAddr !== prevAddr || memWdata !== prevWdata || memWe !== prevWe)) begin
      holdErr++;
    end
    prevWait = memReq && !memAck;
    prevAddr = memAddr;
    prevWdata = memWdata;
    prevWe = memWe;
    if (memReq && memAck) begin
      if (memWe) mem[memAddr] = memWdata;
      beatAddr.push_back(memAddr);
      beatData.push_back(memWdata);
      beatWe.push_back(memWe);
      waitCnt = 0;
    end else if (memReq) begin
      waitCnt = waitCnt + 1;
    end else begin
      waitCnt = 0;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; drives one start cycle and returns at the next negedge
  task automatic applyStimulus(input bit st, input logic [15:0] b, input logic [31:0] wd, input bit fl);
    isStore = st;
    baseAddr = b;
    vecWdata = wd;
    flush = fl;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    flush = 1'b0;
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "/busy"}, busy, 0);
    checkOutput({name, "/done"}, done, 0);
    checkOutput({name, "/err"}, err, 0);
    checkOutput({name, "/req"}, memReq, 0);
    checkOutput({name, "/we"}, memWe, 0);
    checkOutput({name, "/addr"}, memAddr, 0);
    checkOutput({name, "/wdata"}, memWdata, 0);
    checkOutput({name, "/rdata"}, vecRdata, 0);
  endtask

  task automatic runTxn(input string name, input bit st, input logic [15:0] b,
                        input logic [31:0] wd, input int dly,
                        input logic [31:0] expR, input int expLat);
    int cyc;
    int busyCnt;
    int beatBase;
    int holdBase;
    ackDelay = dly;
    ackNever = 1'b0;
    beatBase = beatAddr.size();
    holdBase = holdErr;
    applyStimulus(st, b, wd, 1'b0);
    cyc = 1;
    busyCnt = 0;
    checkOutput({name, "/req1"}, memReq, 1);
    checkOutput({name, "/addr0"}, memAddr, b);
    checkOutput({name, "/err1"}, err, 0);
    while (!done && cyc < 400) begin
      if (busy) busyCnt++;
      @(negedge clock);
      cyc++;
    end
    checkOutput({name, "/doneSeen"}, done, 1);
    checkOutput({name, "/latency"}, cyc, expLat);
    checkOutput({name, "/busyCycles"}, busyCnt, LANES * (dly + 1));
    checkOutput({name, "/busyAtDone"}, busy, 0);
    checkOutput({name, "/reqAtDone"}, memReq, 0);
    checkOutput({name, "/errAtDone"}, err, 0);
    checkOutput({name, "/rdata"}, vecRdata, expR);
    checkOutput({name, "/beats"}, beatAddr.size() - beatBase, LANES);
    for (int i = 0; i < LANES; i++) begin
      if (beatBase + i < beatAddr.size()) begin
        checkOutput($sformatf("%s/addr%0d", name, i), beatAddr[beatBase + i], laneAddr(b, i));
        checkOutput($sformatf("%s/we%0d", name, i), beatWe[beatBase + i], st);
        if (st) checkOutput($sformatf("%s/wd%0d", name, i), beatData[beatBase + i], wd[8*i +: 8]);
      end
    end
    if (dly > 0) checkOutput({name, "/hold"}, holdErr - holdBase, 0);
  endtask

  task automatic checkStoredBytes(input string name, input logic [15:0] b);
    for (int i = 0; i < LANES; i++)
      checkOutput($sformatf("%s/mem%0d", name, i), memRead(laneAddr(b, i)), refRead(laneAddr(b, i)));
  endtask

  initial begin
    int nd;
    int cyc;
    int reqCnt;
    int beatBase;
    bit st;
    logic [15:0] b;
    logic [31:0] wd;
    int dly;
    logic [31:0] expR;

    vecTable[0] = '{1'b1, 16'h0010, 32'h44332211, 0, 32'h00000000, 5};
    vecTable[1] = '{1'b0, 16'h0010, 32'h00000000, 0, 32'h44332211, 5};
    vecTable[2] = '{1'b1, 16'h0200, 32'hDEADBEEF, 2, 32'h44332211, 13};
    vecTable[3] = '{1'b1, 16'hFFFE, 32'hD4C3B2A1, 0, 32'h44332211, 5};
    vecTable[4] = '{1'b0, 16'hFFFE, 32'h00000000, 0, 32'hD4C3B2A1, 5};
    vecTable[5] = '{1'b0, 16'h0200, 32'h00000000, 1, 32'hDEADBEEF, 9};

    // Reset state
    repeat (2) @(negedge clock);
    checkAllZero("reset");
    rstN = 1'b1;
    @(negedge clock);

    // Directed vector table: load, store with waits, address wrap
    for (int k = 0; k < 6; k++) begin
      runTxn($sformatf("vec%0d", k), vecTable[k].isStore, vecTable[k].base,
             vecTable[k].wdata, vecTable[k].delay, vecTable[k].expRdata, vecTable[k].expLat);
      if (vecTable[k].isStore) begin
        modelStore(vecTable[k].base, vecTable[k].wdata, LANES);
        checkStoredBytes($sformatf("vec%0d", k), vecTable[k].base);
      end
      @(negedge clock);
    end

    // Back-to-back: second start lands in the DONE cycle of the first
    runTxn("b2bA", 1'b0, 16'h0010, 32'h0, 0, 32'h44332211, 5);
    runTxn("b2bB", 1'b0, 16'hFFFE, 32'h0, 0, 32'hD4C3B2A1, 5);
    @(negedge clock);

    // start during REQ is ignored: single done, only the first access's lanes
    ackDelay = 0;
    beatBase = beatAddr.size();
    applyStimulus(1'b0, 16'h0010, 32'h0, 1'b0);
    baseAddr = 16'h5555;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    nd = 0;
    repeat (8) begin
      if (done) nd++;
      @(negedge clock);
    end
    checkOutput("startInReq/doneCount", nd, 1);
    checkOutput("startInReq/beats", beatAddr.size() - beatBase, LANES);
    checkOutput("startInReq/lastAddr", beatAddr[beatAddr.size() - 1], 16'h0013);
    checkOutput("startInReq/rdata", vecRdata, 32'h44332211);

    // flush on lane 2 of a store with wait states: lanes 0-1 written only
    ackDelay = 2;
    beatBase = beatAddr.size();
    applyStimulus(1'b1, 16'h0300, 32'h11223344, 1'b0);
    repeat (6) @(negedge clock);
    checkOutput("flush/lane2Addr", memAddr, 16'h0302);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    checkOutput("flush/reqDropped", memReq, 0);
    checkOutput("flush/busyDropped", busy, 0);
    nd = 0;
    repeat (8) begin
      if (done) nd++;
      @(negedge clock);
    end
    checkOutput("flush/noDone", nd, 0);
    checkOutput("flush/beats", beatAddr.size() - beatBase, 2);
    modelStore(16'h0300, 32'h11223344, 2);
    checkStoredBytes("flush", 16'h0300);

    // flush and start in the same IDLE cycle: start is dropped
    ackDelay = 0;
    beatBase = beatAddr.size();
    applyStimulus(1'b0, 16'h0010, 32'h0, 1'b1);
    checkOutput("flushStart/req", memReq, 0);
    checkOutput("flushStart/busy", busy, 0);
    nd = 0;
    repeat (4) begin
      if (done) nd++;
      @(negedge clock);
    end
    checkOutput("flushStart/noDone", nd, 0);
    checkOutput("flushStart/beats", beatAddr.size() - beatBase, 0);

    // Reset during lane 1 aborts at once with no further memory beats
    beatBase = beatAddr.size();
    applyStimulus(1'b0, 16'h0010, 32'h0, 1'b0);
    @(negedge clock);
    checkOutput("midReset/lane1Addr", memAddr, 16'h0011);
    rstN = 1'b0;
    #1;
    checkAllZero("midReset");
    repeat (2) @(negedge clock);
    checkOutput("midReset/beats", beatAddr.size() - beatBase, 1);
    rstN = 1'b1;
    @(negedge clock);
    runTxn("afterReset", 1'b0, 16'h0010, 32'h0, 0, 32'h44332211, 5);
    @(negedge clock);

`ifdef VMEM_TIMEOUT_EN
    // Ack never arrives: lane 0 gives up after TIMEOUT request cycles
    ackNever = 1'b1;
    applyStimulus(1'b0, 16'h0040, 32'h0, 1'b0);
    cyc = 1;
    reqCnt = 0;
    while (!done && cyc < 100) begin
      if (memReq) reqCnt++;
      @(negedge clock);
      cyc++;
    end
    checkOutput("timeout/reqCycles", reqCnt, TIMEOUT);
    checkOutput("timeout/done", done, 1);
    checkOutput("timeout/err", err, 1);
    checkOutput("timeout/req", memReq, 0);
    @(negedge clock);
    checkOutput("timeout/errSticky", err, 1);
    ackNever = 1'b0;
`else
    // Without the timeout feature a missing ack waits indefinitely
    ackNever = 1'b1;
    applyStimulus(1'b0, 16'h0040, 32'h0, 1'b0);
    repeat (20) @(negedge clock);
    checkOutput("noTimeout/reqHeld", memReq, 1);
    checkOutput("noTimeout/err", err, 0);
    checkOutput("noTimeout/busy", busy, 1);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    checkOutput("noTimeout/flushed", memReq, 0);
    ackNever = 1'b0;
`endif
    runTxn("recover", 1'b0, 16'h0010, 32'h0, 0, 32'h44332211, 5);
    lastRdata = 32'h44332211;

    // Randomized accesses against the reference model
    for (int k = 0; k < 24; k++) begin
      st = 1'($urandom_range(0, 1));
      b = 16'($urandom_range(0, 65535));
      if (k % 6 == 0) b = 16'hFFFD;
      wd = $urandom;
      dly = $urandom_range(0, 3);
      expR = st ? lastRdata : modelLoad(b);
      runTxn($sformatf("rnd%0d", k), st, b, wd, dly, expR, LANES * (dly + 1) + 1);
      if (st) begin
        modelStore(b, wd, LANES);
        checkStoredBytes($sformatf("rnd%0d", k), b);
      end else begin
        lastRdata = expR;
      end
      if ($urandom_range(0, 1) == 1) @(negedge clock);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
